arb_rr_2: RTL

Two-input round-robin packet arbiter with valid/ready handshakes on both inputs and the output. It sits directly upstream of the 2:1 select stage: it decides which of two sources owns the output, and registers that source's data together with the select index. Grants are packet-atomic: once a source wins, it holds the output until its beat marked `last` is accepted. Used wherever two producers share one datapath lane.

---
 rtl/arb_rr_2_pkg.sv | 13 +
 rtl/rr_pick_2.sv | 15 +
 rtl/arb_rr_2.sv | 102 ++++++++++
 3 files changed

// File: rtl/arb_rr_2_pkg.sv
// Shared definitions for the two-input round-robin packet arbiter.
package arb_rr_2_pkg;

  localparam int unsigned DataWDefault = 8;

  // 2'd3 is unused and falls back to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin pick: a lone valid source wins, a tie goes to prio_i.
module rr_pick_2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prio_i,
  output logic winner_o,
  output logic any_valid_o
);

  always_comb begin
    any_valid_o = valid0_i | valid1_i;
    winner_o    = (valid0_i & valid1_i) ? prio_i : valid1_i;
  end

endmodule

// File: rtl/arb_rr_2.sv
// Two-input round-robin packet arbiter with a registered output stage that
// carries the select index for the downstream 2:1 mux.
module arb_rr_2
  import arb_rr_2_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic              in0_last,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic              in1_last,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              winner, any_valid;
  logic              load, own_en, grant, accept;
  logic              beat_last;
  logic [DATA_W-1:0] beat_data;

  rr_pick_2 u_pick (
    .valid0_i    (in0_valid),
    .valid1_i    (in1_valid),
    .prio_i      (prio_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    own_en  = 1'b0;
    grant   = 1'b0;
    load    = !out_valid || out_ready;

    case (state_q)
      StIdle: begin
        own_en = any_valid;
        grant  = winner;
      end
      StLock0: begin
        own_en = 1'b1;
        grant  = 1'b0;
      end
      StLock1: begin
        own_en = 1'b1;
        grant  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Readys are forced low while reset is held so no beat is consumed then.
    in0_ready = rst_n && own_en && load && !grant;
    in1_ready = rst_n && own_en && load && grant;
    accept    = grant ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
    beat_last = grant ? in1_last : in0_last;
    beat_data = grant ? in1_data : in0_data;

    if (accept) begin
      if (beat_last) begin
        state_d = StIdle;
        prio_d  = ~grant;
      end else begin
        state_d = grant ? StLock1 : StLock0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_last  <= beat_last;
        out_sel   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
